// File: rtl/bin_to_digits_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_digits_seq_pkg
// Shared types and constants for the sequential binary-to-digit converter.
//   state_t      : converter FSM states (IDLE -> SHIFT -> LOAD -> IDLE)
//   N0..N9       : 8-bit display codes for decimal digits (active-low
//                  segments, bit order dp,g,f,e,d,c,b,a)
//   NBLANK       : all-segments-off code used for suppressed leading zeros
// -----------------------------------------------------------------------------
package bin_to_digits_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [7:0] N0     = 8'hC0;
  localparam logic [7:0] N1     = 8'hF9;
  localparam logic [7:0] N2     = 8'hA4;
  localparam logic [7:0] N3     = 8'hB0;
  localparam logic [7:0] N4     = 8'h99;
  localparam logic [7:0] N5     = 8'h92;
  localparam logic [7:0] N6     = 8'h82;
  localparam logic [7:0] N7     = 8'hF8;
  localparam logic [7:0] N8     = 8'h80;
  localparam logic [7:0] N9     = 8'h90;
  localparam logic [7:0] NBLANK = 8'hFF;

endpackage

// File: rtl/bin_to_digits_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_digits_seq_if
// Request/result bundle of the converter.
//   i_start : conversion request (only honoured while idle)
//   i_bin   : binary value, captured on the accepting edge
//   o_busy  : converter is not idle
//   o_valid : one-cycle pulse, result fields updated this cycle
//   o_err   : captured value exceeded 10**DIGITS-1
//   o_bcd   : raw BCD, ones digit in [3:0]
//   o_out   : display codes, ones digit in [7:0]
// master = producer of requests, slave = converter.
// -----------------------------------------------------------------------------
interface bin_to_digits_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_valid;
  logic                  o_err;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [8*DIGITS-1:0]   o_out;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_valid, o_err, o_bcd, o_out
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_valid, o_err, o_bcd, o_out
  );
endinterface

// File: rtl/bin_to_digits_seq_digit_code_lut.sv
// -----------------------------------------------------------------------------
// digit_code_lut
// Combinational BCD nibble to 8-bit display code. Non-decimal nibbles
// (10..15) show as zero.
//   bcd  : 4-bit BCD digit in
//   code : 8-bit display code out
// -----------------------------------------------------------------------------
module digit_code_lut
  import bin_to_digits_seq_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] code
);

  always_comb begin
    case (bcd)
      4'd0:    code = N0;
      4'd1:    code = N1;
      4'd2:    code = N2;
      4'd3:    code = N3;
      4'd4:    code = N4;
      4'd5:    code = N5;
      4'd6:    code = N6;
      4'd7:    code = N7;
      4'd8:    code = N8;
      4'd9:    code = N9;
      default: code = N0;
    endcase
  end

endmodule

// File: rtl/bin_to_digits_seq.sv
// -----------------------------------------------------------------------------
// bin_to_digits_seq
// Sequential binary to decimal display-code converter using shift-add-3
// (double dabble), one input bit per clock.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : bin_to_digits_seq_if.slave (start/bin in, busy/valid/err/bcd/out)
// Parameters: BIN_W (input width), DIGITS (decimal digits produced).
// Build option: define BIN_TO_DIGITS_SEQ_BLANK_EN to blank leading zeros
// (all digits but the ones digit) in o_out; o_bcd is never blanked.
// Accept edge -> BIN_W SHIFT cycles -> one LOAD cycle -> o_valid pulse.
// -----------------------------------------------------------------------------
module bin_to_digits_seq
  import bin_to_digits_seq_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bin_to_digits_seq_if.slave   bus
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          OUT_W   = 8 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_sel;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               accept;
  logic               last_shift;
  logic [7:0]         code [DIGITS];
  logic [OUT_W-1:0]   out_next;

  assign accept     = (state_q == IDLE) && bus.i_start;
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // ---------------------------------------------------------------- FSM
  // NOTE: state and data registers use non-blocking (<=) so every flop
  // samples pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_start) state_d = SHIFT;
      SHIFT:   if (last_shift)  state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy = (state_q != IDLE);
  end

  // ---------------------------------------------------------- datapath
  // Add-3 correction on every nibble that would reach >= 10 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // NOTE: the shift datapath carries no reset; it is fully reloaded on
  // every accept and its contents are never observed before that.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      bin_q <= bus.i_bin;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  // The bit shifted out of the top nibble can only be set when the input
  // was already out of range; folding it in keeps err_q self-consistent.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  err_q <= 1'b0;
    else if (accept)            err_q <= (32'(bus.i_bin) > MAX_VAL);
    else if (state_q == SHIFT)  err_q <= err_q | bcd_adj[BCD_W-1];
  end

  // Out-of-range results are reported as all-zero digits.
  assign bcd_sel = err_q ? '0 : bcd_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_lut
    digit_code_lut u_lut (
      .bcd  (bcd_sel[4*g +: 4]),
      .code (code[g])
    );
  end

  always_comb begin
`ifdef BIN_TO_DIGITS_SEQ_BLANK_EN
    logic leading;
    leading = 1'b1;
`endif
    out_next = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      out_next[8*d +: 8] = code[d];
`ifdef BIN_TO_DIGITS_SEQ_BLANK_EN
      // Walk from the most significant digit; stop blanking at the first
      // non-zero digit, and never blank the ones digit.
      leading = leading && (bcd_sel[4*d +: 4] == 4'd0);
      if (leading && (d != 0)) out_next[8*d +: 8] = NBLANK;
`else
`endif
    end
  end

  // ------------------------------------------------------ result regs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      bus.o_err   <= 1'b0;
      bus.o_bcd   <= '0;
      bus.o_out   <= {DIGITS{N0}};
    end else begin
      bus.o_valid <= (state_q == LOAD);
      if (state_q == LOAD) begin
        bus.o_bcd <= bcd_sel;
        bus.o_out <= out_next;
        bus.o_err <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_digits_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_digits_seq
// Two converters: A (BIN_W=10, DIGITS=3) for directed cases, B (BIN_W=7,
// DIGITS=2) swept over all inputs. A cycle-level reference model per
// instance predicts busy/valid/err/bcd/out from decimal arithmetic; a
// compare process checks every cycle; directed literals pin the model.
// -----------------------------------------------------------------------------
module tb_bin_to_digits_seq;

  localparam int A_W = 10;
  localparam int A_D = 3;
  localparam int B_W = 7;
  localparam int B_D = 2;
  localparam int MAX_A = 999;
  localparam int MAX_B = 99;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  logic [7:0] seg [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] BLANK = 8'hFF;

`ifdef BIN_TO_DIGITS_SEQ_BLANK_EN
  localparam logic [23:0] OUT_0  = {8'hFF, 8'hFF, 8'hC0};
  localparam logic [23:0] OUT_57 = {8'hFF, 8'h92, 8'hF8};
  localparam logic [23:0] OUT_42 = {8'hFF, 8'h99, 8'hA4};
  localparam logic [23:0] OUT_7  = {8'hFF, 8'hFF, 8'hF8};
`else
  localparam logic [23:0] OUT_0  = {8'hC0, 8'hC0, 8'hC0};
  localparam logic [23:0] OUT_57 = {8'hC0, 8'h92, 8'hF8};
  localparam logic [23:0] OUT_42 = {8'hC0, 8'h99, 8'hA4};
  localparam logic [23:0] OUT_7  = {8'hC0, 8'hC0, 8'hF8};
`endif
  localparam logic [23:0] OUT_RST = {8'hC0, 8'hC0, 8'hC0};

  bin_to_digits_seq_if #(.BIN_W(A_W), .DIGITS(A_D)) bus_a ();
  bin_to_digits_seq_if #(.BIN_W(B_W), .DIGITS(B_D)) bus_b ();

  bin_to_digits_seq #(.BIN_W(A_W), .DIGITS(A_D)) dut_a (
    .i_clk (clk), .i_rst (rst), .bus (bus_a));
  bin_to_digits_seq #(.BIN_W(B_W), .DIGITS(B_D)) dut_b (
    .i_clk (clk), .i_rst (rst), .bus (bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference
  function automatic logic [63:0] exp_bcd(input int v, input int nd);
    logic [63:0] r = '0;
    int val = (v > 10 ** nd - 1) ? 0 : v;
    int p = 1;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'((val / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_out(input int v, input int nd);
    logic [63:0] r = '0;
    int val = (v > 10 ** nd - 1) ? 0 : v;
    int p = 1;
    for (int k = 0; k < nd; k++) begin
      logic [7:0] b;
      b = seg[(val / p) % 10];
`ifdef BIN_TO_DIGITS_SEQ_BLANK_EN
      if (k > 0 && val < p) b = BLANK;
`endif
      r[8*k +: 8] = b;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] rst_out(input int nd);
    logic [63:0] r = '0;
    for (int k = 0; k < nd; k++) r[8*k +: 8] = seg[0];
    return r;
  endfunction

  // Countdown model: cycles remaining until the result appears.
  int          a_cnt, b_cnt;
  int          a_pend, b_pend;
  logic        a_ev, b_ev, a_ee, b_ee;
  logic [63:0] a_eb, b_eb, a_eo, b_eo;

  always @(posedge clk) begin
    a_ev <= 1'b0;
    if (rst) begin
      a_cnt <= 0; a_ee <= 1'b0; a_eb <= '0; a_eo <= rst_out(A_D);
    end else if (a_cnt == 0) begin
      if (bus_a.i_start) begin a_pend <= int'(bus_a.i_bin); a_cnt <= A_W + 1; end
    end else begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin
        a_ev <= 1'b1; a_ee <= (a_pend > MAX_A);
        a_eb <= exp_bcd(a_pend, A_D); a_eo <= exp_out(a_pend, A_D);
      end
    end
  end

  always @(posedge clk) begin
    b_ev <= 1'b0;
    if (rst) begin
      b_cnt <= 0; b_ee <= 1'b0; b_eb <= '0; b_eo <= rst_out(B_D);
    end else if (b_cnt == 0) begin
      if (bus_b.i_start) begin b_pend <= int'(bus_b.i_bin); b_cnt <= B_W + 1; end
    end else begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin
        b_ev <= 1'b1; b_ee <= (b_pend > MAX_B);
        b_eb <= exp_bcd(b_pend, B_D); b_eo <= exp_out(b_pend, B_D);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_busy",  64'(bus_a.o_busy),  64'(a_cnt != 0));
      check("a_valid", 64'(bus_a.o_valid), 64'(a_ev));
      check("a_err",   64'(bus_a.o_err),   64'(a_ee));
      check("a_bcd",   64'(bus_a.o_bcd),   a_eb);
      check("a_out",   64'(bus_a.o_out),   a_eo);
      check("b_busy",  64'(bus_b.o_busy),  64'(b_cnt != 0));
      check("b_valid", 64'(bus_b.o_valid), 64'(b_ev));
      check("b_err",   64'(bus_b.o_err),   64'(b_ee));
      check("b_bcd",   64'(bus_b.o_bcd),   b_eb);
      check("b_out",   64'(bus_b.o_out),   b_eo);
    end
  end

  // ----------------------------------------------------------- stimulus
  task automatic drive(input bit sel, input bit s, input int v);
    if (sel) begin bus_b.i_start = s; bus_b.i_bin = 7'(v); end
    else     begin bus_a.i_start = s; bus_a.i_bin = 10'(v); end
  endtask

  // Called at a negedge. Requests v; for the first `hold` cycles after
  // that keeps i_start high with i_bin=alt. Returns the cycle index of
  // o_valid (accept cycle = 0) and the number of busy cycles seen.
  task automatic convert(input bit sel, input int v, input int hold, input int alt,
                         output int lat, output int busy_n);
    drive(sel, 1'b1, v);
    lat = 0;
    busy_n = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (sel ? bus_b.o_busy : bus_a.o_busy) busy_n++;
      if (sel ? bus_b.o_valid : bus_a.o_valid) break;
      if (lat <= hold) drive(sel, 1'b1, alt);
      else             drive(sel, 1'b0, alt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, bn, nvalid;
    rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", 64'(bus_a.o_valid), 64'(0));
    check("rst_err",   64'(bus_a.o_err),   64'(0));
    check("rst_bcd",   64'(bus_a.o_bcd),   64'(12'h000));
    check("rst_out",   64'(bus_a.o_out),   64'(OUT_RST));
    rst = 1'b0;
    @(negedge clk);

    convert(1'b0, 0, 0, 0, lat, bn);
    check("v0_latency", 64'(lat), 64'(12));
    check("v0_busy",    64'(bn),  64'(11));
    check("v0_bcd",     64'(bus_a.o_bcd), 64'(12'h000));
    check("v0_out",     64'(bus_a.o_out), 64'(OUT_0));
    check("v0_err",     64'(bus_a.o_err), 64'(0));

    convert(1'b0, 999, 0, 0, lat, bn);
    check("v999_busy", 64'(bn), 64'(11));
    check("v999_bcd",  64'(bus_a.o_bcd), 64'(12'h999));
    check("v999_out",  64'(bus_a.o_out), 64'({8'h90, 8'h90, 8'h90}));
    check("v999_err",  64'(bus_a.o_err), 64'(0));

    convert(1'b0, 1000, 0, 0, lat, bn);
    check("v1000_err", 64'(bus_a.o_err), 64'(1));
    check("v1000_bcd", 64'(bus_a.o_bcd), 64'(0));
    check("v1000_out", 64'(bus_a.o_out), 64'(OUT_0));
    convert(1'b0, 1023, 0, 0, lat, bn);
    check("v1023_err", 64'(bus_a.o_err), 64'(1));
    check("v1023_out", 64'(bus_a.o_out), 64'(OUT_0));

    // Start held high with a different value while busy: ignored.
    convert(1'b0, 57, 5, 300, lat, bn);
    check("v57_latency", 64'(lat), 64'(12));
    check("v57_bcd",     64'(bus_a.o_bcd), 64'(12'h057));
    check("v57_out",     64'(bus_a.o_out), 64'(OUT_57));
    // Back-to-back: request issued in the o_valid cycle.
    convert(1'b0, 300, 0, 0, lat, bn);
    check("v300_latency", 64'(lat), 64'(12));
    check("v300_bcd",     64'(bus_a.o_bcd), 64'(12'h300));
    check("v300_out",     64'(bus_a.o_out), 64'({8'hB0, 8'hC0, 8'hC0}));

    // Reset in the middle of a conversion aborts it.
    drive(1'b0, 1'b1, 512);
    @(negedge clk);
    drive(1'b0, 1'b0, 512);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus_a.o_valid) nvalid++;
    end
    check("abort_no_valid", 64'(nvalid), 64'(0));
    check("abort_bcd",      64'(bus_a.o_bcd), 64'(0));
    check("abort_out",      64'(bus_a.o_out), 64'(OUT_RST));
    convert(1'b0, 42, 0, 0, lat, bn);
    check("v42_bcd", 64'(bus_a.o_bcd), 64'(12'h042));
    check("v42_out", 64'(bus_a.o_out), 64'(OUT_42));

    convert(1'b0, 7, 0, 0, lat, bn);
    check("v7_out", 64'(bus_a.o_out), 64'(OUT_7));
    convert(1'b0, 0, 0, 0, lat, bn);
    check("v0b_out", 64'(bus_a.o_out), 64'(OUT_0));

    // Small instance: every input value.
    @(negedge clk);
    for (int v = 0; v < 128; v++) begin
      convert(1'b1, v, 0, 0, lat, bn);
      check("b_latency", 64'(lat), 64'(9));
      check("b_err_rule", 64'(bus_b.o_err), 64'(v >= 100));
      if (v == 0)   check("b_busy0", 64'(bn), 64'(8));
      if (v == 99)  check("b_bcd99",  64'(bus_b.o_bcd), 64'(8'h99));
      if (v == 100) check("b_bcd100", 64'(bus_b.o_bcd), 64'(8'h00));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_digits_seq.md
Name: bin_to_digits_seq

Overview:
- Sequential, parametrised binary-to-decimal display-code converter. Successor to the fixed 7-bit, two-digit combinational separator.
- Uses the shift-add-3 (double-dabble) algorithm, one bit per clock, with a start/valid handshake.
- Each decimal digit is emitted as its 8-bit `n0..`n9 display code.
- Sits between counter/score logic and the display drivers.

Parameters:
- BIN_W, 10, width of the binary input.
- DIGITS, 3, number of decimal digits produced; maximum representable value is MAX_VAL = 10**DIGITS-1 (localparam).

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  conversion request; sampled only in IDLE.
- i_bin  input  BIN_W  binary value; latched on the accepting edge.
- o_busy  output  1  high whenever the state is not IDLE.
- o_valid  output  1  one-cycle pulse; o_out/o_bcd/o_err updated this cycle.
- o_err  output  1  latched input exceeded MAX_VAL.
- o_bcd  output  4*DIGITS  raw BCD; ones digit in [3:0].
- o_out  output  8*DIGITS  display codes; ones digit in [7:0], tens in [15:8], and so on.

Behaviour:
- Reset (i_rst=1 at the edge):
  - state=IDLE, o_valid=0, o_err=0, o_bcd=0, every o_out byte=`n0.
  - Reset mid-conversion aborts it; no o_valid follows.
- States: IDLE -> SHIFT -> LOAD -> IDLE.
- IDLE, i_start=1:
  - Latch i_bin into the shift register.
  - Clear the BCD accumulator and bit counter; set err_q = (i_bin > MAX_VAL).
  - Go to SHIFT.
- IDLE, i_start=0: hold.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3 (combinational correction).
  - Then {bcd, bin} shifts left one bit; counter increments.
  - After BIN_W shifts, go to LOAD.
- LOAD (one cycle), at the leaving edge:
  - Register o_bcd and o_out from the accumulator; o_err=err_q; o_valid=1; go to IDLE.
  - If err_q=1: o_bcd=0 and all o_out bytes=`n0 (error case).
- Latency: o_valid is high in the cycle BIN_W+2 edges after the edge that accepted i_start (BIN_W+1 cycles later).
  - Default latency is 12 cycles from accept to o_valid.
- i_start while o_busy=1: ignored; no queuing.
- Back-to-back: i_start in the o_valid cycle (state already IDLE) is accepted.
- o_valid deasserts the next cycle unless another LOAD completes.
- Outputs hold their last result until the next LOAD or reset.
- Accumulator width is 4*DIGITS. Bits shifted beyond the top nibble are discarded; that is only reachable when o_err=1.
- i_bin changes after the accept edge have no effect.

Optional Feature:
- Macro: BIN_TO_DIGITS_SEQ_BLANK_EN.
- Defined:
  - Leading-zero digits (all except the ones digit) are output as `nBLANK.
  - The ones digit always shows `n0..`n9.
  - Error case: ones=`n0, rest=`nBLANK.
  - o_bcd is unaffected.
- Undefined: all digits are always shown, leading zeros included.

Decomposition:
- Shared constants header CONSTANTS.v: existing `n0..`n9, plus new `nBLANK (all-segments-off code).
- Sub-module digit_code_lut:
  - Combinational, 4-bit BCD in, 8-bit code out.
  - Values 10..15 map to `n0.
  - Instantiated DIGITS times via generate.

Test Plan:
- Reset, then i_bin=0 with i_start pulse -> o_valid in the 12th cycle after accept, o_bcd=12'h000, o_out={`n0,`n0,`n0}, o_err=0.
- i_bin=999 -> o_bcd=12'h999, o_out={`n9,`n9,`n9}, o_err=0; o_busy high for exactly 11 cycles.
- i_bin=1000, then i_bin=1023 -> o_err=1, o_bcd=0, all `n0.
- i_bin=57 accepted; i_start=1 and i_bin=300 for the next 5 cycles -> single result 12'h057; no second o_valid. Then i_start in the o_valid cycle with i_bin=300 -> next result 12'h300.
- Start i_bin=512; assert i_rst at cycle 5 -> no o_valid; outputs all `n0; a subsequent i_bin=42 gives 12'h042.
- With BIN_TO_DIGITS_SEQ_BLANK_EN: i_bin=7 -> o_out={`nBLANK,`nBLANK,`n7}; i_bin=0 -> {`nBLANK,`nBLANK,`n0}.
- Parameter sweep BIN_W=7, DIGITS=2: all inputs 0..127 checked against a reference model; err exactly for >=100.
